ldpc_iteration_controller: RTL

- Sequencer running in the decoder's divided-clock domain, directly downstream of the clock divider.
- Accepts one frame start via valid/ready, then drives the core through four phases: LLR load, check-node update, variable-node update, syndrome check.
- Repeats until the syndrome passes, MAX_ITER is reached, or an abort arrives.
- Reports the result through a valid/ready done interface.

---
 rtl/ldpc_iteration_controller_if.sv | 30 +++
 rtl/ldpc_iteration_controller.sv | 118 +++++++++++
 2 files changed

// File: rtl/ldpc_iteration_controller_if.sv
// Frame start, core strobes and result handshake between the LDPC iteration controller and its environment.
// master = controller side, slave = frame source / decoder core / result consumer side.
interface ldpc_iteration_controller_if #(
  parameter int ADDR_W = 8,
  parameter int ITER_W = 6
);
  logic              start_valid;
  logic              start_ready;
  logic              abort;
  logic              syndrome_ok;
  logic              load_en;
  logic              cn_en;
  logic              vn_en;
  logic [ADDR_W-1:0] phase_addr;
  logic              busy;
  logic              done_valid;
  logic              done_ready;
  logic              converged;
  logic [ITER_W-1:0] iter_count;

  modport master (
    input  start_valid, abort, syndrome_ok, done_ready,
    output start_ready, load_en, cn_en, vn_en, phase_addr, busy, done_valid, converged, iter_count
  );

  modport slave (
    output start_valid, abort, syndrome_ok, done_ready,
    input  start_ready, load_en, cn_en, vn_en, phase_addr, busy, done_valid, converged, iter_count
  );
endinterface

// File: rtl/ldpc_iteration_controller.sv
// LDPC decode sequencer: LOAD, then CN -> VN -> CHK sweeps until syndrome pass, MAX_ITER or abort.
// Moore outputs straight from state/counter flops; start taken only in IDLE, result held in DONE until done_ready.
module ldpc_iteration_controller #(
  parameter int LOAD_CYCLES = 128,
  parameter int CN_CYCLES   = 64,
  parameter int VN_CYCLES   = 128,
  parameter int MAX_ITER    = 20,
  parameter int ADDR_W      = 8,
  parameter int ITER_W      = 6
) (
  input logic                        clk_in,
  input logic                        rst_n,
  ldpc_iteration_controller_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_CN, S_VN, S_CHK, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic              conv_q, conv_d;
  logic              phase_last;

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      iter_q  <= '0;
      conv_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      iter_q  <= iter_d;
      conv_q  <= conv_d;
    end
  end

  always_comb begin
    phase_last = 1'b0;
    case (state_q)
      S_LOAD:  phase_last = (cnt_q == ADDR_W'(LOAD_CYCLES - 1));
      S_CN:    phase_last = (cnt_q == ADDR_W'(CN_CYCLES - 1));
      S_VN:    phase_last = (cnt_q == ADDR_W'(VN_CYCLES - 1));
      default: phase_last = 1'b0;
    endcase
  end

  // The counter is zeroed on every phase exit, so it is always 0 outside LOAD/CN/VN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    iter_d  = iter_q;
    conv_d  = conv_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start_valid) begin
          state_d = S_LOAD;
          cnt_d   = '0;
          iter_d  = '0;
          conv_d  = 1'b0;
        end
      end
      S_LOAD, S_CN, S_VN: begin
        if (bus.abort) begin
          state_d = S_DONE;
          cnt_d   = '0;
          conv_d  = 1'b0;
        end else if (phase_last) begin
          cnt_d = '0;
          if (state_q == S_LOAD) begin
            state_d = S_CN;
          end else if (state_q == S_CN) begin
            state_d = S_VN;
          end else begin
            state_d = S_CHK;
            iter_d  = iter_q + ITER_W'(1);
          end
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      S_CHK: begin
        cnt_d = '0;
        if (bus.abort) begin
          state_d = S_DONE;
          conv_d  = 1'b0;
        end else if (bus.syndrome_ok) begin
          state_d = S_DONE;
          conv_d  = 1'b1;
        end else if (iter_q == ITER_W'(MAX_ITER)) begin
          state_d = S_DONE;
          conv_d  = 1'b0;
        end else begin
          state_d = S_CN;
        end
      end
      S_DONE: begin
        if (bus.done_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.start_ready = (state_q == S_IDLE);
    bus.load_en     = (state_q == S_LOAD);
    bus.cn_en       = (state_q == S_CN);
    bus.vn_en       = (state_q == S_VN);
    bus.phase_addr  = (state_q inside {S_LOAD, S_CN, S_VN}) ? cnt_q : '0;
    bus.busy        = (state_q inside {S_LOAD, S_CN, S_VN, S_CHK});
    bus.done_valid  = (state_q == S_DONE);
    bus.converged   = conv_q;
    bus.iter_count  = iter_q;
  end

endmodule
